// File: rtl/layer00_seq_if.sv
// Control/status bundle between the layer sequencer and its environment:
// frame control, MAC issue strobe with pixel coordinates, and result return.
interface layer00_seq_if #(
    parameter int COL_W = 9
);
    logic             iStart;
    logic [COL_W-1:0] iCols;
    logic [COL_W-1:0] iRows;
    logic             iW_ready;
    logic             iStall;
    logic             iOut_vld;
    logic             oMac_vld;
    logic [COL_W-1:0] oCol;
    logic [COL_W-1:0] oRow;
    logic             oBusy;
    logic             oDone;
    logic             oErr;

    modport master (
        output iStart, iCols, iRows, iW_ready, iStall, iOut_vld,
        input  oMac_vld, oCol, oRow, oBusy, oDone, oErr
    );

    modport slave (
        input  iStart, iCols, iRows, iW_ready, iStall, iOut_vld,
        output oMac_vld, oCol, oRow, oBusy, oDone, oErr
    );
endinterface

// File: rtl/layer00_seq.sv
// Layer sequencer: walks a cols x rows output frame, issuing pixels to the MAC bank
// under an outstanding-result cap. LAYER00_SEQ_TIMEOUT_EN adds a DRAIN watchdog.
//
// state | meaning
// IDLE  | waiting for iStart
// WLOAD | waiting for kernels (iW_ready)
// RUN   | issuing pixels
// DRAIN | all pixels issued, waiting for outstanding results
// DONE  | one-cycle completion pulse
module layer00_seq #(
    parameter int COL_W    = 9,
    parameter int PIPE_LAT = 8,
    parameter int MAX_OUT  = 16
) (
    input  logic         clk,
    input  logic         rst,
    layer00_seq_if.slave bus
);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);
    localparam logic [COL_W-1:0] ONE     = COL_W'(1);

    typedef enum logic [2:0] {IDLE, WLOAD, RUN, DRAIN, DONE} state_t;

    state_t           state;
    state_t           stateNext;
    logic [COL_W-1:0] colsLat;
    logic [COL_W-1:0] rowsLat;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] row;
    logic [OUT_W-1:0] outCnt;
    logic [OUT_W-1:0] outNext;
    logic             err;
    logic             startAcc;
    logic             issue;
    logic             lastCol;
    logic             lastPix;
    logic             underflow;
    logic             timeout;

    assign startAcc  = (state == IDLE) && bus.iStart;
    assign issue     = (state == RUN) && bus.iW_ready && !bus.iStall
                       && (outCnt < OUT_MAX) && !rst;
    assign lastCol   = (col == colsLat - ONE);
    assign lastPix   = lastCol && (row == rowsLat - ONE);
    assign underflow = bus.iOut_vld && (outCnt == '0) && !issue;

    always_comb begin
        outNext = outCnt;
        if (issue && !bus.iOut_vld) begin
            outNext = outCnt + 1'b1;
        end else if (!issue && bus.iOut_vld && (outCnt != '0)) begin
            outNext = outCnt - 1'b1;
        end
    end

`ifdef LAYER00_SEQ_TIMEOUT_EN
    // wdCnt = cycles elapsed since the last result (or DRAIN entry); the DONE
    // cycle lands 4*PIPE_LAT cycles after the last result.
    localparam int WD_W = $clog2(4 * PIPE_LAT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(4 * PIPE_LAT - 1);

    logic [WD_W-1:0] wdCnt;

    assign timeout = (state == DRAIN) && !bus.iOut_vld && (wdCnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst || (state != DRAIN) || bus.iOut_vld) begin
            wdCnt <= WD_W'(1);
        end else if (wdCnt != WD_LAST) begin
            wdCnt <= wdCnt + 1'b1;
        end
    end
`else
    // No watchdog; PIPE_LAT only sizes the watchdog when it is built.
    assign timeout = 1'b0 & (PIPE_LAT < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (bus.iStart) begin
                    stateNext = ((bus.iCols == '0) || (bus.iRows == '0)) ? DONE : WLOAD;
                end
            end
            WLOAD: begin
                if (bus.iW_ready) stateNext = RUN;
            end
            RUN: begin
                if (issue && lastPix) stateNext = DRAIN;
            end
            DRAIN: begin
                if (timeout || (outNext == '0)) stateNext = DONE;
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            colsLat <= '0;
            rowsLat <= '0;
            col     <= '0;
            row     <= '0;
            outCnt  <= '0;
            err     <= 1'b0;
        end else begin
            outCnt <= outNext;
            if (startAcc) begin
                colsLat <= bus.iCols;
                rowsLat <= bus.iRows;
                col     <= '0;
                row     <= '0;
            end else if (issue && !lastPix) begin
                if (lastCol) begin
                    col <= '0;
                    row <= row + ONE;
                end else begin
                    col <= col + ONE;
                end
            end
            // A fault in the same cycle as a start still leaves the flag set.
            if (underflow || timeout) begin
                err <= 1'b1;
            end else if (startAcc) begin
                err <= 1'b0;
            end
        end
    end

    assign bus.oMac_vld = issue;
    assign bus.oCol     = col;
    assign bus.oRow     = row;
    assign bus.oBusy    = !rst && ((state == WLOAD) || (state == RUN) || (state == DRAIN));
    assign bus.oDone    = !rst && (state == DONE);
    assign bus.oErr     = err;
endmodule

// File: tb/tb_layer00_seq.sv
// Directed bench for layer00_seq (MAX_OUT=2 so backpressure is reachable);
// LAYER00_SEQ_TIMEOUT_EN also enables the watchdog scenario.
module tb_layer00_seq;
    localparam int COL_W = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       autoRet = 1'b0;
    logic       manOut = 1'b0;
    logic [7:0] retPipe = '0;
    int         checks = 0;
    int         errors = 0;

    layer00_seq_if #(.COL_W(COL_W)) bus ();

    layer00_seq #(.COL_W(COL_W), .PIPE_LAT(8), .MAX_OUT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Post-processing model: each issued pixel returns 8 cycles later.
    always @(posedge clk) retPipe <= rst ? 8'd0 : {retPipe[6:0], bus.oMac_vld};
    assign bus.iOut_vld = autoRet ? retPipe[7] : manOut;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.iStart = 1'b0;
        autoRet = 1'b0;
        manOut = 1'b0;
        bus.iW_ready = 1'b0;
        bus.iStall = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic pulseStart(input int cols, input int rows);
        bus.iCols = COL_W'(cols);
        bus.iRows = COL_W'(rows);
        bus.iStart = 1'b1;
        step();
        bus.iStart = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.iStart = 1'b0;
        bus.iCols = '0;
        bus.iRows = '0;
        bus.iW_ready = 1'b0;
        bus.iStall = 1'b0;
        step();
        step();
        checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.oBusy); end
        checks++; if (bus.oDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.oDone); end
        checks++; if (bus.oMac_vld !== 1'b0) begin errors++; $display("FAIL reset_mac: got %b expected 0", bus.oMac_vld); end
        checks++; if (bus.oErr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.oErr); end
        checks++; if (bus.oCol !== '0 || bus.oRow !== '0) begin errors++; $display("FAIL reset_coord: got (%0d,%0d) expected (0,0)", bus.oCol, bus.oRow); end
        rst = 1'b0;
        step();
        checks++; if (bus.oBusy !== 1'b0 || bus.oDone !== 1'b0) begin errors++; $display("FAIL reset_idle: got busy=%b done=%b expected 0/0", bus.oBusy, bus.oDone); end
    endtask

    task automatic test_nominal();
        int nIss = 0;
        int nRet = 0;
        int lastRetAt = -1;
        int doneAt = -1;
        int errSeen = 0;
        doReset();
        autoRet = 1'b1;
        bus.iW_ready = 1'b1;
        pulseStart(4, 2);
        for (int cyc = 0; cyc < 200 && doneAt < 0; cyc++) begin
            if (bus.oMac_vld === 1'b1) begin
                checks++;
                if (bus.oCol !== COL_W'(nIss % 4) || bus.oRow !== COL_W'(nIss / 4)) begin
                    errors++;
                    $display("FAIL nominal_order: issue %0d got (%0d,%0d) expected (%0d,%0d)", nIss, bus.oCol, bus.oRow, nIss % 4, nIss / 4);
                end
                nIss++;
            end
            if (bus.iOut_vld === 1'b1) begin
                nRet++;
                if (nRet == 8) lastRetAt = cyc;
            end
            if (bus.oErr !== 1'b0) errSeen = 1;
            if (bus.oDone === 1'b1) doneAt = cyc;
            step();
        end
        checks++; if (nIss != 8) begin errors++; $display("FAIL nominal_count: got %0d issues expected 8", nIss); end
        checks++; if (doneAt < 0 || doneAt != lastRetAt + 1) begin errors++; $display("FAIL nominal_done: got done at %0d expected %0d", doneAt, lastRetAt + 1); end
        checks++; if (errSeen != 0) begin errors++; $display("FAIL nominal_err: got err seen=%0d expected 0", errSeen); end
        checks++; if (bus.oDone !== 1'b0 || bus.oBusy !== 1'b0) begin errors++; $display("FAIL nominal_after: got done=%b busy=%b expected 0/0", bus.oDone, bus.oBusy); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        doReset();
        bus.iW_ready = 1'b1;
        bus.iStall = 1'b1;
        pulseStart(4, 2);
        step();
        checks++; if (bus.oMac_vld !== 1'b0) begin errors++; $display("FAIL stall_blocks: got %b expected 0", bus.oMac_vld); end
        checks++; if (bus.oBusy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b expected 1", bus.oBusy); end
        bus.iStall = 1'b0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (bus.oMac_vld === 1'b1) n++;
            step();
        end
        checks++; if (n != 2) begin errors++; $display("FAIL bp_cap: got %0d issues expected 2", n); end
        checks++; if (bus.oMac_vld !== 1'b0 || bus.oBusy !== 1'b1) begin errors++; $display("FAIL bp_hold: got mac=%b busy=%b expected 0/1", bus.oMac_vld, bus.oBusy); end
        manOut = 1'b1;
        step();
        manOut = 1'b0;
        #1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.oMac_vld === 1'b1) n++;
            step();
        end
        checks++; if (n != 1) begin errors++; $display("FAIL bp_release: got %0d issues expected 1", n); end
    endtask

    // Continues the backpressure frame: 2 outstanding, candidate pixel (3,0).
    task automatic test_simultaneous();
        int n = 0;
        manOut = 1'b1;
        #1;
        checks++; if (bus.oMac_vld !== 1'b0) begin errors++; $display("FAIL simul_first: got %b expected 0", bus.oMac_vld); end
        step();
        checks++; if (bus.oMac_vld !== 1'b1 || bus.oCol !== 9'd3) begin errors++; $display("FAIL simul_both: got mac=%b col=%0d expected 1/3", bus.oMac_vld, bus.oCol); end
        n = 1;
        step();
        manOut = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (bus.oMac_vld === 1'b1) n++;
            step();
        end
        checks++; if (n != 2) begin errors++; $display("FAIL simul_count: got %0d issues expected 2", n); end
        checks++; if (bus.oErr !== 1'b0) begin errors++; $display("FAIL simul_err: got %b expected 0", bus.oErr); end
    endtask

    task automatic test_wready();
        int seen = 0;
        int idleSeen = 0;
        int doneSeen = 0;
        doReset();
        autoRet = 1'b1;
        bus.iW_ready = 1'b0;
        pulseStart(3, 1);
        for (int i = 0; i < 5; i++) begin
            if (bus.oMac_vld === 1'b1) seen++;
            if (bus.oBusy !== 1'b1) idleSeen++;
            step();
        end
        checks++; if (seen != 0 || idleSeen != 0) begin errors++; $display("FAIL wload_wait: got issues=%0d notbusy=%0d expected 0/0", seen, idleSeen); end
        bus.iW_ready = 1'b1;
        step();
        checks++; if (bus.oMac_vld !== 1'b1 || bus.oCol !== 9'd0) begin errors++; $display("FAIL run_first: got mac=%b col=%0d expected 1/0", bus.oMac_vld, bus.oCol); end
        step();
        bus.iW_ready = 1'b0;
        #1;
        checks++; if (bus.oMac_vld !== 1'b0 || bus.oCol !== 9'd1 || bus.oBusy !== 1'b1) begin errors++; $display("FAIL suspend: got mac=%b col=%0d busy=%b expected 0/1/1", bus.oMac_vld, bus.oCol, bus.oBusy); end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.oMac_vld === 1'b1 || bus.oBusy !== 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL suspend_hold: got %0d bad cycles expected 0", seen); end
        bus.iW_ready = 1'b1;
        #1;
        checks++; if (bus.oMac_vld !== 1'b1 || bus.oCol !== 9'd1) begin errors++; $display("FAIL resume: got mac=%b col=%0d expected 1/1", bus.oMac_vld, bus.oCol); end
        for (int i = 0; i < 60 && doneSeen == 0; i++) begin
            if (bus.oDone === 1'b1) doneSeen = 1;
            else step();
        end
        checks++; if (doneSeen != 1 || bus.oErr !== 1'b0) begin errors++; $display("FAIL wready_done: got done=%0d err=%b expected 1/0", doneSeen, bus.oErr); end
    endtask

    task automatic test_zero_size();
        doReset();
        pulseStart(0, 3);
        checks++; if (bus.oDone !== 1'b1 || bus.oBusy !== 1'b0 || bus.oMac_vld !== 1'b0) begin errors++; $display("FAIL zero_cols: got done=%b busy=%b mac=%b expected 1/0/0", bus.oDone, bus.oBusy, bus.oMac_vld); end
        step();
        checks++; if (bus.oDone !== 1'b0 || bus.oBusy !== 1'b0) begin errors++; $display("FAIL zero_after: got done=%b busy=%b expected 0/0", bus.oDone, bus.oBusy); end
        pulseStart(5, 0);
        checks++; if (bus.oDone !== 1'b1 || bus.oBusy !== 1'b0) begin errors++; $display("FAIL zero_rows: got done=%b busy=%b expected 1/0", bus.oDone, bus.oBusy); end
        step();
        checks++; if (bus.oDone !== 1'b0) begin errors++; $display("FAIL zero_rows_after: got done=%b expected 0", bus.oDone); end
    endtask

    task automatic test_underflow();
        doReset();
        manOut = 1'b1;
        step();
        manOut = 1'b0;
        #1;
        checks++; if (bus.oErr !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b expected 1", bus.oErr); end
        step();
        checks++; if (bus.oErr !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %b expected 1", bus.oErr); end
        pulseStart(0, 1);
        checks++; if (bus.oErr !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %b expected 0", bus.oErr); end
    endtask

    task automatic test_reset_midframe();
        int found = 0;
        int doneSeen = 0;
        doReset();
        autoRet = 1'b1;
        bus.iW_ready = 1'b1;
        pulseStart(4, 2);
        for (int i = 0; i < 50 && found == 0; i++) begin
            if (bus.oMac_vld === 1'b1 && bus.oCol === 9'd2 && bus.oRow === 9'd0) found = 1;
            else step();
        end
        checks++; if (found != 1) begin errors++; $display("FAIL midrst_reach: got found=%0d expected 1", found); end
        rst = 1'b1;
        #1;
        checks++; if (bus.oMac_vld !== 1'b0) begin errors++; $display("FAIL midrst_mac: got %b expected 0", bus.oMac_vld); end
        step();
        rst = 1'b0;
        #1;
        checks++; if (bus.oBusy !== 1'b0 || bus.oCol !== '0 || bus.oRow !== '0 || bus.oDone !== 1'b0) begin errors++; $display("FAIL midrst_state: got busy=%b col=%0d row=%0d done=%b expected 0/0/0/0", bus.oBusy, bus.oCol, bus.oRow, bus.oDone); end
        for (int i = 0; i < 20; i++) begin
            if (bus.oDone === 1'b1 || bus.oMac_vld === 1'b1) doneSeen++;
            step();
        end
        checks++; if (doneSeen != 0) begin errors++; $display("FAIL midrst_quiet: got %0d done/issue cycles expected 0", doneSeen); end
    endtask

`ifdef LAYER00_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int doneAt = -1;
        doReset();
        bus.iW_ready = 1'b1;
        pulseStart(2, 1);
        step();
        step();
        step();
        checks++; if (bus.oBusy !== 1'b1 || bus.oMac_vld !== 1'b0) begin errors++; $display("FAIL to_drain: got busy=%b mac=%b expected 1/0", bus.oBusy, bus.oMac_vld); end
        manOut = 1'b1;
        step();
        manOut = 1'b0;
        #1;
        for (int k = 1; k <= 40 && doneAt < 0; k++) begin
            if (bus.oDone === 1'b1) doneAt = k;
            else step();
        end
        checks++; if (doneAt != 32) begin errors++; $display("FAIL to_done: got done %0d cycles after result expected 32", doneAt); end
        checks++; if (bus.oErr !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", bus.oErr); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_simultaneous();
        test_wready();
        test_zero_size();
        test_underflow();
        test_reset_midframe();
`ifdef LAYER00_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
